// File: rtl/fsm_moore_lector.sv
// Card-reader front end: deserialises an ID + even-parity frame, classifies it
// into access code L and holds L until the barrier FSM acknowledges with C.
module fsm_moore_lector #(
    parameter int              ID_W     = 8,
    parameter logic [ID_W-1:0] AUTH_LO  = 'h10,
    parameter logic [ID_W-1:0] AUTH_HI  = 'h1F,
    parameter logic [ID_W-1:0] BLOCK_ID = 'h15,
    parameter int              GAP_MAX  = 16,
    parameter int              HOLD_MAX = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            D,
    input  logic            V,
    input  logic            C,
    output logic [1:0]      L,
    output logic            busy,
    output logic            err,
    output logic [ID_W-1:0] id_out
);

    localparam int BW = $clog2(ID_W + 1) + 1;
    localparam int GW = $clog2(GAP_MAX) + 1;
    localparam int HW = $clog2(HOLD_MAX) + 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(ID_W + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_EVAL,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W:0]   frame_q, frame_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]      l_q, l_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] id_out_q, id_out_d;
    logic [ID_W-1:0] rx_id;

    // Frame is shifted in MSB first, so the parity bit ends up in bit 0
    assign rx_id = frame_q[ID_W:1];

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        l_d        = l_q;
        id_out_d   = id_out_q;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                l_d = 2'b00;
                if (V) begin
                    frame_d   = {frame_q[ID_W-1:0], D};
                    bit_cnt_d = BW'(1);
                    gap_cnt_d = '0;
                    state_d   = S_RECV;
                end
            end
            S_RECV: begin
                if (V) begin
                    frame_d   = {frame_q[ID_W-1:0], D};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    gap_cnt_d = '0;
                    if (bit_cnt_d == BIT_LAST) begin
                        state_d = S_EVAL;
                    end
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    err_d     = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                id_out_d   = rx_id;
                hold_cnt_d = '0;
                bit_cnt_d  = '0;
                gap_cnt_d  = '0;
                state_d    = S_HOLD;
                // Parity failure outranks the blocked ID, which outranks the range
                if (^frame_q) begin
                    l_d   = 2'b00;
                    err_d = 1'b1;
                end else if (rx_id == BLOCK_ID) begin
                    l_d = 2'b10;
                end else if (rx_id >= AUTH_LO && rx_id <= AUTH_HI) begin
                    l_d = 2'b11;
                end else begin
                    l_d = 2'b01;
                end
            end
            S_HOLD: begin
                if (C) begin
                    state_d    = S_IDLE;
                    l_d        = 2'b00;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_IDLE;
                    l_d        = 2'b00;
                    hold_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            hold_cnt_q <= '0;
            l_q        <= 2'b00;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            id_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            l_q        <= l_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            id_out_q   <= id_out_d;
        end
    end

    assign L      = l_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign id_out = id_out_q;

endmodule

// File: tb/tb_fsm_moore_lector.sv
// Directed bench for fsm_moore_lector: frame classes, gap/hold timeouts,
// handshake with C and asynchronous reset.
module tb_fsm_moore_lector;

    logic       clk;
    logic       reset;
    logic       D;
    logic       V;
    logic       C;
    logic [1:0] L;
    logic       busy;
    logic       err;
    logic [7:0] id_out;

    int n_checks;
    int n_errors;
    int err_seen;
    int err_consec;
    logic err_prev;

    fsm_moore_lector dut (
        .clk    (clk),
        .reset  (reset),
        .D      (D),
        .V      (V),
        .C      (C),
        .L      (L),
        .busy   (busy),
        .err    (err),
        .id_out (id_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts err pulses and back-to-back err cycles
    always @(negedge clk) begin
        if (reset) begin
            err_prev = 1'b0;
        end else begin
            if (err) err_seen++;
            if (err && err_prev) err_consec++;
            err_prev = err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        V = 1'b1;
        D = b;
        tick();
        V = 1'b0;
        D = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic par,
                              input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(id[i]);
            ticks(gap);
        end
        send_bit(par);
    endtask

    task automatic ack();
        C = 1'b1;
        tick();
        C = 1'b0;
    endtask

    int e0;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        err_seen   = 0;
        err_consec = 0;
        err_prev   = 1'b0;
        D = 1'b0;
        V = 1'b0;
        C = 1'b0;
        reset = 1'b1;
        ticks(2);
        check("rst_L", 32'(L), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_id", 32'(id_out), 0);
        reset = 1'b0;
        tick();

        // C outside HOLD has no effect
        ack();
        check("idle_c_busy", 32'(busy), 0);
        check("idle_c_L", 32'(L), 0);

        // Authorised frame, then acknowledge
        send_frame(8'h12, 1'b0, 0);
        ticks(2);
        check("auth_L", 32'(L), 3);
        check("auth_busy", 32'(busy), 1);
        check("auth_id", 32'(id_out), 32'h12);
        ack();
        check("auth_ack_L", 32'(L), 0);
        check("auth_ack_busy", 32'(busy), 0);
        check("auth_no_err", 32'(err_seen), 0);

        // Blocked beats range; out-of-range ID is unknown
        send_frame(8'h15, 1'b1, 0);
        ticks(2);
        check("block_L", 32'(L), 2);
        ack();
        send_frame(8'h40, 1'b1, 0);
        ticks(2);
        check("unk_L", 32'(L), 1);
        check("unk_id", 32'(id_out), 32'h40);
        ack();
        check("unk_ack_busy", 32'(busy), 0);

        // Parity error
        e0 = err_seen;
        send_frame(8'h12, 1'b1, 0);
        ticks(2);
        check("par_L", 32'(L), 0);
        check("par_busy", 32'(busy), 1);
        check("par_err_pulses", 32'(err_seen - e0), 1);
        check("par_err_low", 32'(err), 0);
        ack();
        check("par_ack_busy", 32'(busy), 0);

        // Gap timeout after 16 idle cycles
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ticks(15);
        check("gap15_busy", 32'(busy), 1);
        tick();
        check("gap16_busy", 32'(busy), 0);
        check("gap16_err", 32'(err), 1);
        check("gap16_L", 32'(L), 0);
        tick();
        check("gap_err_1cyc", 32'(err), 0);

        // 15-cycle gaps between bits are tolerated
        send_frame(8'h1A, 1'b1, 15);
        ticks(2);
        check("gap_ok_L", 32'(L), 3);
        check("gap_ok_id", 32'(id_out), 32'h1A);
        ack();

        // Hold timeout, with stray bits during HOLD
        send_frame(8'h12, 1'b0, 0);
        ticks(2);
        for (int i = 0; i < 20; i++) send_bit(1'(i % 3));
        check("hold_bits_L", 32'(L), 3);
        check("hold_bits_id", 32'(id_out), 32'h12);
        ticks(1002);
        check("hold_1023_busy", 32'(busy), 1);
        check("hold_1023_L", 32'(L), 3);
        tick();
        check("hold_to_busy", 32'(busy), 0);
        check("hold_to_L", 32'(L), 0);
        check("hold_to_err", 32'(err), 1);
        tick();

        // C on the timeout cycle wins, no err; also low range bound
        send_frame(8'h10, 1'b1, 0);
        ticks(2);
        check("lo_bound_L", 32'(L), 3);
        ticks(1022);
        check("race_busy_pre", 32'(busy), 1);
        ack();
        check("race_busy", 32'(busy), 0);
        check("race_err", 32'(err), 0);
        check("race_L", 32'(L), 0);

        // Async reset mid-RECV
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_recv_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // Async reset mid-HOLD
        send_frame(8'h12, 1'b0, 0);
        ticks(2);
        check("pre_rst_L", 32'(L), 3);
        #2 reset = 1'b1;
        #1;
        check("rst_hold_L", 32'(L), 0);
        check("rst_hold_busy", 32'(busy), 0);
        check("rst_hold_id", 32'(id_out), 0);
        reset = 1'b0;
        tick();

        send_frame(8'h1F, 1'b1, 0);
        ticks(2);
        check("post_rst_L", 32'(L), 3);
        check("post_rst_id", 32'(id_out), 32'h1F);
        ack();

        check("err_consec", 32'(err_consec), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
